// File: rtl/gnn_beat_pkg.sv
// Shared definitions for the neighbour-list beat splitter and its downstream lane-mask decoder.
package gnn_beat_pkg;

    localparam int LANES      = 64;
    localparam int LANE_W     = 6;
    localparam int DEF_ID_W   = 16;
    localparam int DEF_ADDR_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    typedef struct packed {
        logic              full;
        logic [LANE_W-1:0] cnt;
        logic              last;
    } beat_ctl_t;

    // Default-width view of a complete beat, as seen by the downstream decoder.
    typedef struct packed {
        logic [DEF_ID_W-1:0]   node;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  full;
        logic [LANE_W-1:0]     cnt;
        logic                  first;
        logic                  last;
    } beat_t;

    // The caller supplies its own compares, so this stays independent of the degree width.
    function automatic beat_ctl_t calc_beat(input logic gt_lanes,
                                            input logic eq_lanes,
                                            input logic [LANE_W-1:0] low);
        beat_ctl_t b;
        if (gt_lanes) begin
            b.full = 1'b1;
            b.cnt  = '0;
            b.last = 1'b0;
        end else if (eq_lanes) begin
            b.full = 1'b1;
            b.cnt  = '0;
            b.last = 1'b1;
        end else begin
            b.full = 1'b0;
            b.cnt  = low;
            b.last = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/nbr_beat_splitter.sv
// Splits each node descriptor into beats of up to 64 lanes (full flag + tail count).
//   state   | meaning
//   IDLE    | no descriptor held, in_ready=1
//   EMIT    | presenting beats of the held descriptor
module nbr_beat_splitter
    import gnn_beat_pkg::*;
#(
    parameter int ID_W   = 16,
    parameter int DEG_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ID_W-1:0]   in_node,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [DEG_W-1:0]  in_deg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_node,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_full,
    output logic [LANE_W-1:0] out_cnt,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);

    state_t           state;
    logic [DEG_W-1:0] rem;
    logic [DEG_W-1:0] rem_next;
    beat_ctl_t        ctl_load;
    beat_ctl_t        ctl_next;
    logic             beat_acc;

    assign beat_acc = out_valid & out_ready;
    assign in_ready = (state == ST_IDLE) | ((state == ST_EMIT) & beat_acc & out_last);
    assign rem_next = rem - DEG_W'(LANES);
    assign ctl_load = calc_beat(in_deg > DEG_W'(LANES), in_deg == DEG_W'(LANES),
                                in_deg[LANE_W-1:0]);
    assign ctl_next = calc_beat(rem_next > DEG_W'(LANES), rem_next == DEG_W'(LANES),
                                rem_next[LANE_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rem       <= '0;
            out_valid <= 1'b0;
            out_node  <= '0;
            out_addr  <= '0;
            out_full  <= 1'b0;
            out_cnt   <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state     <= ST_EMIT;
                        rem       <= in_deg;
                        out_valid <= 1'b1;
                        out_node  <= in_node;
                        out_addr  <= in_base;
                        out_full  <= ctl_load.full;
                        out_cnt   <= ctl_load.cnt;
                        out_last  <= ctl_load.last;
                        out_first <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (beat_acc) begin
                        if (!out_last) begin
                            rem       <= rem_next;
                            out_addr  <= out_addr + ADDR_W'(LANES);
                            out_full  <= ctl_next.full;
                            out_cnt   <= ctl_next.cnt;
                            out_last  <= ctl_next.last;
                            out_first <= 1'b0;
                        end else if (in_valid) begin
                            // Chain straight into the next node without an idle cycle.
                            rem       <= in_deg;
                            out_node  <= in_node;
                            out_addr  <= in_base;
                            out_full  <= ctl_load.full;
                            out_cnt   <= ctl_load.cnt;
                            out_last  <= ctl_load.last;
                            out_first <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
